// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the 8N1 UART receive path.
package uart_rx_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  // Data bits per 8N1 frame
  localparam int BITS_PER_FRAME = 8;

  // Counter value at which a bit cell is sampled (integer division intended)
  function automatic int mid_point(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO with push/pop/clear.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             pop_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop needs data present; a push into a full FIFO only lands if a pop
  // frees the slot in the same cycle. clr discards both.
  assign pop_ok  = pop & ~empty & ~clr;
  assign push_ok = push & ~clr & (~full | pop_ok);

  assign level = wr_ptr_reg - rd_ptr_reg;

  // Head byte falls through; forced to 0 when empty so reset reads as 0
  assign data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  // Pointer update; clear returns both pointers to the origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver feeding a FWFT byte FIFO, with framing-error,
// overflow and end-of-line reporting.
module uart_rx_capture
  import uart_rx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 32,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          eol_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  input  logic                          clr_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [15:0]                   drop_cnt_o,
  output logic                          busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(mid_point(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(BITS_PER_FRAME - 1);

  logic            rx_meta_reg;
  logic            rx_s_reg;
  rx_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            push_req;
  logic            frame_err_next;
  logic            frame_err_reg;
  logic            eol_reg;
  logic            overflow_reg;
  logic [15:0]     drop_cnt_reg;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push_ok;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx_i;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // FSM state, bit timer, bit index and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  // Next-state logic; push_req fires in the stop-bit sample cycle
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    push_req       = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_en_i && !rx_s_reg) state_next = START;
      end
      START: begin
        if (cnt_reg == MID_CNT) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            state_next = IDLE;          // start bit did not hold: glitch
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          shift_next = {rx_s_reg, shift_reg[7:1]};   // LSB arrives first
          if (bit_idx_reg == LAST_BIT) state_next = STOP;
          else bit_idx_next = bit_idx_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            push_req   = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;   // ride out a break before rearming
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_reg) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_i),
    .push      (push_req),
    .push_data (shift_reg),
    .pop       (ready_i),
    .data      (data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (fifo_push_ok),
    .level     (level_o)
  );

  // Status pulses and sticky overflow bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      eol_reg       <= 1'b0;
      overflow_reg  <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      frame_err_reg <= frame_err_next;
      eol_reg       <= fifo_push_ok && (shift_reg == EOL_CHAR);
      if (clr_i) begin
        overflow_reg <= 1'b0;
        drop_cnt_reg <= '0;
      end else if (push_req && !fifo_push_ok) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign valid_o     = ~fifo_empty;
  assign eol_o       = eol_reg;
  assign frame_err_o = frame_err_reg;
  assign overflow_o  = overflow_reg;
  assign drop_cnt_o  = drop_cnt_reg;
  assign busy_o      = (state_reg != IDLE);

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable 8N1 UART receiver with an output FIFO. It consumes the SoC's serial TX line (pulpino_top uart_tx) at the chip boundary.
- Turns the bitstream into a byte stream with valid/ready handshake for a downstream console, checker or scoreboard.
- Flags framing errors, FIFO overflow and end-of-line (0x0A).
- Default timing matches the 100 MHz system clock at 3.125 Mbaud (32 clocks per bit).

Parameters:
CLKS_PER_BIT, 32, system clocks per UART bit; must be >= 8; an even value is recommended.
FIFO_DEPTH, 16, number of byte entries; must be a power of two >= 2.
EOL_CHAR, 8'h0A, byte value that pulses eol_o when written into the FIFO.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_i  in  1  serial input, idle high; asynchronous to clk
rx_en_i  in  1  receive enable; when 0 the FSM holds IDLE and no new frames start
data_o  out  8  FIFO head byte
valid_o  out  1  FIFO non-empty
ready_i  in  1  consumer accept; a pop happens on valid_o & ready_i
eol_o  out  1  one-cycle pulse when a byte equal to EOL_CHAR is pushed
frame_err_o  out  1  one-cycle pulse when the stop bit samples 0
overflow_o  out  1  sticky; set when a byte arrives while the FIFO is full; cleared by clr_i
clr_i  in  1  synchronous clear of overflow_o, drop_cnt_o and the FIFO contents
level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
drop_cnt_o  out  16  bytes lost to overflow; saturates at 16'hFFFF
busy_o  out  1  FSM is not in IDLE

Behaviour:
- Reset values: all outputs 0, except data_o (don't-care, driven 0). The FIFO is empty and the FSM is in IDLE.
- Input synchronizer:
  - rx_i passes through a 2-flop synchronizer; both flops reset to 1.
  - All logic uses the synchronized value rx_s.
  - Fixed input latency is 2 clocks.
- Bit counter: counts 0..CLKS_PER_BIT-1. The mid-point is CLKS_PER_BIT/2 - 1 (integer division).
- FSM states and transitions:
  - IDLE: if rx_en_i & ~rx_s, clear the counter and go to START.
  - START: at the mid-point, re-sample rx_s.
    - If rx_s is 1, treat it as a glitch and return to IDLE; no pulse is produced.
    - Otherwise reset the counter and go to DATA with bit index 0.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into the shift register.
    - The shift is LSB first: shift right and insert at bit 7.
    - After the 8th sample, go to STOP.
  - STOP: at one full bit period after the last data sample, sample rx_s.
    - If 1: push the byte (subject to full) and go to IDLE.
    - If 0: pulse frame_err_o, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This blocks break conditions.
- Clearing rx_en_i mid-frame does not abort the frame; rx_en_i gates only the IDLE->START transition.
- Push timing:
  - The push happens in the clock of the stop-bit sample.
  - valid_o rises on the next clock, so latency from the stop-bit mid-point to valid_o is 1 clk.
  - eol_o pulses in the same cycle valid_o first reflects the byte (registered with the push).
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address; full and empty come from the pointer MSB compare.
  - data_o is first-word-fall-through, driven from mem[rd_ptr].
- Simultaneous push and pop:
  - When full: the pop frees a slot, so the push succeeds. No overflow; level is unchanged.
  - When empty: only the push takes effect (FWFT requires valid before pop).
- Full with push and no pop: the byte is dropped, overflow_o is set, drop_cnt_o increments, and eol_o is still suppressed.
- clr_i:
  - Empties the FIFO and clears overflow_o and drop_cnt_o.
  - A push in the same cycle is discarded.
  - clr_i does not affect the FSM.
- Asynchronous reset mid-frame: everything returns to reset state immediately. The partial frame is lost; after release the FSM restarts in IDLE.
- Width rules: level_o = wr_ptr - rd_ptr with modulo wrap over the pointer width.

Decomposition:
- Package uart_rx_pkg holds:
  - typedef rx_state_e {IDLE, START, DATA, STOP, WAIT_IDLE}
  - localparam BITS_PER_FRAME = 8
  - a function computing the mid-point from CLKS_PER_BIT
- One sub-module, uart_rx_fifo: parameterized FWFT synchronous FIFO with push/pop/clr, full/empty/level. It is reused elsewhere.

Test Plan:
- Send 0x55 then 0xA3 at 32 clk/bit with ready_i=1 -> data_o shows 0x55 then 0xA3; each valid_o appears 1 clk after the stop-bit mid-point; no frame_err_o.
- Send "OK\n" (0x4F, 0x4B, 0x0A) -> exactly one eol_o pulse, coincident with the first cycle of valid_o for 0x0A; level_o peaks at 3 with ready_i=0.
- Drive a 10-clk low glitch on rx_i while idle -> FSM returns to IDLE; no push, no frame_err_o, level_o stays 0.
- Send 0x3C with stop bit forced 0, holding rx low for 3 bit-times -> frame_err_o pulses once; nothing pushed; busy_o stays 1 until rx returns high, then the next frame 0x7E is received correctly.
- Hold ready_i=0 and send 18 bytes with FIFO_DEPTH=16 -> level_o=16, overflow_o=1, drop_cnt_o=2; clr_i -> level_o=0, overflow_o=0, drop_cnt_o=0.
- Assert rst during DATA bit 4 of 0xF0, release, then send 0x12 -> only 0x12 appears; all outputs are 0 during reset.
